// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared types and default parameter values for the bounce
// stimulus generator, its testbench and any loopback top.
//   bg_state_t      - pattern FSM state encoding
//   *Def constants  - default MAX_BOUNCE / UNIT_W / SETTLE_W values
package bounce_gen_pkg;

    localparam int unsigned MaxBounceDef = 4;
    localparam int unsigned UnitWDef     = 8;
    localparam int unsigned SettleWDef   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap,
        StSettle
    } bg_state_t;

endpackage

// File: rtl/bounce_gen_phase_timer.sv
// phase_timer: loadable down-counter that measures the length of one pattern
// phase.
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   load_i      load a new phase length this cycle
//   load_val_i  phase length in cycles (must be >= 1)
//   zero_o      high during the final cycle of the current phase
module phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Stored as length-1 so that zero_o marks the last cycle of the phase and the
    // next phase can be loaded on the same edge without a dead cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: on request, drives btn_out through k = 1..n bounces (level for
// k*unit cycles, then ~level for unit cycles), then holds level for settle
// cycles and pulses done.
//   clk, rst         clock, synchronous active-low reset
//   start            request, sampled only while idle
//   level            target settled level
//   n_bounce         bounce count (clamped to MAX_BOUNCE)
//   unit, settle     bounce unit and settle lengths (0 treated as 1)
//   btn_out          emulated button output
//   busy, done       pattern in progress / one-cycle completion pulse
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int unsigned MAX_BOUNCE = MaxBounceDef,
    parameter int unsigned UNIT_W     = UnitWDef,
    parameter int unsigned SETTLE_W   = SettleWDef
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              level,
    input  logic [$clog2(MAX_BOUNCE+1)-1:0]   n_bounce,
    input  logic [UNIT_W-1:0]                 unit,
    input  logic [SETTLE_W-1:0]               settle,
    output logic                              btn_out,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned NW     = $clog2(MAX_BOUNCE + 1);
    // Wide enough for MAX_BOUNCE * (2^UNIT_W - 1).
    localparam int unsigned PhaseW = UNIT_W + NW;
    // The same timer also measures the settle phase.
    localparam int unsigned TimerW = (PhaseW > SETTLE_W) ? PhaseW : SETTLE_W;

    bg_state_t             state_q;
    logic                  btn_out_q, busy_q, done_q;
    logic                  level_q;
    logic [NW-1:0]         n_q, k_q;
    logic [UNIT_W-1:0]     unit_q;
    logic [SETTLE_W-1:0]   settle_q;
    logic [PhaseW-1:0]     kunit_q;

    logic [NW-1:0]         n_adj;
    logic [UNIT_W-1:0]     unit_adj;
    logic [SETTLE_W-1:0]   settle_adj;
    logic [PhaseW-1:0]     kunit_next;
    logic                  tmr_load, tmr_zero;
    logic [TimerW-1:0]     tmr_val;

    assign n_adj      = (n_bounce > NW'(MAX_BOUNCE)) ? NW'(MAX_BOUNCE) : n_bounce;
    assign unit_adj   = (unit == '0) ? UNIT_W'(1) : unit;
    assign settle_adj = (settle == '0) ? SETTLE_W'(1) : settle;
    // k*unit is built by accumulation as k steps up.
    assign kunit_next = kunit_q + PhaseW'(unit_q);

    // Timer load at every phase entry, with the length of the phase being entered.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = (n_adj != '0) ? TimerW'(unit_adj) : TimerW'(settle_adj);
                end
            end
            StActive: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TimerW'(unit_q);
                end
            end
            StGap: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = (k_q < n_q) ? TimerW'(kunit_next) : TimerW'(settle_q);
                end
            end
            StSettle: begin
                tmr_load = 1'b0;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    phase_timer #(
        .W (TimerW)
    ) u_phase_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Outputs are registered from the current state, so each phase shows on
    // btn_out one edge after the state enters it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            btn_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            level_q   <= 1'b0;
            n_q       <= '0;
            k_q       <= '0;
            unit_q    <= '0;
            settle_q  <= '0;
            kunit_q   <= '0;
        end else begin
            busy_q <= (state_q != StIdle);
            // First idle cycle after a pattern.
            done_q <= (state_q == StIdle) && busy_q;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        level_q  <= level;
                        n_q      <= n_adj;
                        unit_q   <= unit_adj;
                        settle_q <= settle_adj;
                        k_q      <= NW'(1);
                        kunit_q  <= PhaseW'(unit_adj);
                        state_q  <= (n_adj != '0) ? StActive : StSettle;
                    end
                end
                StActive: begin
                    btn_out_q <= level_q;
                    if (tmr_zero) state_q <= StGap;
                end
                StGap: begin
                    btn_out_q <= ~level_q;
                    if (tmr_zero) begin
                        if (k_q < n_q) begin
                            k_q     <= k_q + NW'(1);
                            kunit_q <= kunit_next;
                            state_q <= StActive;
                        end else begin
                            state_q <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    btn_out_q <= level_q;
                    if (tmr_zero) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign btn_out = btn_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: randomized self-checking bench for bounce_gen. The expected
// btn_out waveform of each request is expanded from the bounce rules into a
// queue and compared cycle by cycle together with busy and done.
module tb_bounce_gen;
    import bounce_gen_pkg::*;

    localparam int unsigned MB = MaxBounceDef;
    localparam int unsigned NW = $clog2(MB + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  level = 1'b0;
    logic [NW-1:0]         n_bounce = '0;
    logic [UnitWDef-1:0]   unit = '0;
    logic [SettleWDef-1:0] settle = '0;
    logic                  btn_out, busy, done;

    int tests = 0;
    int fails = 0;

    bounce_gen #(
        .MAX_BOUNCE (MB),
        .UNIT_W     (UnitWDef),
        .SETTLE_W   (SettleWDef)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .level    (level),
        .n_bounce (n_bounce),
        .unit     (unit),
        .settle   (settle),
        .btn_out  (btn_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1);
    end

    task automatic drive_req(input logic l, input int n, input int u, input int s);
        start    = 1'b1;
        level    = l;
        n_bounce = NW'(n);
        unit     = UnitWDef'(u);
        settle   = SettleWDef'(s);
    endtask

    task automatic drive_noise();
        start    = 1'($urandom);
        level    = 1'($urandom);
        n_bounce = NW'($urandom);
        unit     = UnitWDef'($urandom);
        settle   = SettleWDef'($urandom);
    endtask

    // Expected btn_out waveform of one request, one entry per cycle.
    task automatic build_expect(input logic l, input int n, input int u, input int s,
                                output logic q[$]);
        int ne, ue, se;
        ne = (n > int'(MB)) ? int'(MB) : n;
        ue = (u == 0) ? 1 : u;
        se = (s == 0) ? 1 : s;
        q = {};
        for (int k = 1; k <= ne; k++) begin
            for (int j = 0; j < k * ue; j++) q.push_back(l);
            for (int j = 0; j < ue; j++) q.push_back(~l);
        end
        for (int j = 0; j < se; j++) q.push_back(l);
    endtask

    task automatic check_outs(input string tag, input int cyc, input logic eb,
                              input logic ebusy, input logic edone);
        tests++;
        if (btn_out !== eb) begin
            fails++;
            $display("FAIL %s btn_out cycle %0d: got %b want %b", tag, cyc, btn_out, eb);
        end
        tests++;
        if (busy !== ebusy) begin
            fails++;
            $display("FAIL %s busy cycle %0d: got %b want %b", tag, cyc, busy, ebusy);
        end
        tests++;
        if (done !== edone) begin
            fails++;
            $display("FAIL %s done cycle %0d: got %b want %b", tag, cyc, done, edone);
        end
    endtask

    // Request inputs must already be driven. If accepted is set the accepting
    // edge has already passed. With chain set, the next request is presented so
    // that it is sampled on the done cycle.
    task automatic run_pattern(input string tag, input logic l, input int n, input int u,
                               input int s, input bit accepted, input bit chain,
                               input logic nl, input int nn, input int nu, input int ns);
        logic q[$];
        int   d;
        build_expect(l, n, u, s, q);
        d = q.size();
        if (!accepted) @(posedge clk);
        for (int i = 1; i <= d + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i <= d) check_outs(tag, i, q[i-1], 1'b1, 1'b0);
            else        check_outs(tag, i, l, 1'b0, 1'b1);
            if (i < d) drive_noise();
            else if (i == d) begin
                if (chain) drive_req(nl, nn, nu, ns);
                else       start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        drive_req(1'b1, 2, 1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset_with_start", 0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("reset_idle", i, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_directed();
        drive_req(1'b1, 2, 1, 3);
        run_pattern("directed", 1'b1, 2, 1, 3, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_outs("directed_after", 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_fields();
        drive_req(1'b0, 0, 0, 0);
        run_pattern("zero_rel", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive_req(1'b1, 0, 0, 0);
        run_pattern("zero_press", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // Same level as current output still runs a full pattern; n is clamped.
        drive_req(1'b1, 7, 1, 2);
        run_pattern("clamp_same", 1'b1, 7, 1, 2, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 3, 2, 4);
        run_pattern("b2b_first", 1'b0, 3, 2, 4, 1'b0, 1'b1, 1'b1, 2, 3, 2);
        run_pattern("b2b_second", 1'b1, 2, 3, 2, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_gap();
        logic q[$];
        build_expect(1'b1, 4, 2, 3, q);
        drive_req(1'b1, 4, 2, 3);
        @(posedge clk);
        // Cycle 17 is the first cycle of the third gap (2+2+4+2+6 = 16 before it).
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("mid_pre", i, q[i-1], 1'b1, 1'b0);
            drive_noise();
        end
        rst   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outs("mid_reset", 0, 1'b0, 1'b0, 1'b0);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outs("mid_after", 0, 1'b0, 1'b0, 1'b0);
        drive_req(1'b1, 1, 3, 2);
        run_pattern("mid_restart", 1'b1, 1, 3, 2, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic l, nl;
        int   n, u, s, nn, nu, ns;
        bit   acc, chain;
        l = 1'($urandom);
        n = $urandom_range(0, 7);
        u = $urandom_range(0, 5);
        s = $urandom_range(0, 9);
        drive_req(l, n, u, s);
        acc = 1'b0;
        for (int p = 0; p < 24; p++) begin
            nl = 1'($urandom);
            nn = $urandom_range(0, 7);
            nu = $urandom_range(0, 5);
            ns = $urandom_range(0, 9);
            chain = (p < 23) && ($urandom_range(0, 1) == 1);
            run_pattern("random", l, n, u, s, acc, chain, nl, nn, nu, ns);
            if (!chain) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_outs("random_idle", p, l, 1'b0, 1'b0);
                end
                drive_req(nl, nn, nu, ns);
            end
            acc = chain;
            l = nl; n = nn; u = nu; s = ns;
        end
        start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_zero_fields();
        test_back_to_back();
        test_reset_mid_gap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable button-bounce stimulus source: on request it drives a single-bit output through a deterministic pattern of growing bounce pulses, then settles at a target level. It sits on the input side of `debounce`, in place of a physical button, for on-board self-test and loopback benches.

## Interface
- `MAX_BOUNCE`, 4, largest bounce count accepted; larger requests are clamped.
- `UNIT_W`, 8, width of the bounce unit length field.
- `SETTLE_W`, 16, width of the settle length field.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-low.
- `start`  in  1  request; sampled only while idle.
- `level`  in  1  target settled level (1 = press, 0 = release).
- `n_bounce`  in  $clog2(MAX_BOUNCE+1)  bounce count, 0..MAX_BOUNCE.
- `unit`  in  UNIT_W  cycles per bounce unit.
- `settle`  in  SETTLE_W  cycles to hold `level` after the last bounce.
- `btn_out`  out  1  emulated button; drives `debounce` input `btn`.
- `busy`  out  1  pattern in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ACTIVE, GAP, SETTLE.
- IDLE:
  - `btn_out` holds the last settled level.
  - `start`=1 latches `level`, `n_bounce` (clamped to MAX_BOUNCE), `unit` (0 treated as 1) and `settle` (0 treated as 1). Bounce index k is set to 1.
  - Transition to ACTIVE if n≥1, otherwise to SETTLE.
- ACTIVE: drive `level` for k·unit cycles, then go to GAP.
- GAP: drive `~level` for `unit` cycles.
  - If k<n: increment k and return to ACTIVE.
  - Otherwise go to SETTLE.
- SETTLE: drive `level` for `settle` cycles, then return to IDLE with `done` pulsed.
- Request inputs are ignored while busy. Only the latched copies are used during a pattern.
- A pattern is generated even when `level` equals the current `btn_out`.
- Phase counter width: UNIT_W+$clog2(MAX_BOUNCE+1). It must hold MAX_BOUNCE·(2^UNIT_W−1) without overflow.

## Timing
- Reset (`rst`=0 at a rising edge) forces the following values at that edge, including mid-pattern:
  - state IDLE
  - `btn_out`=0
  - `busy`=0
  - `done`=0
  - all latched fields cleared
- All outputs are registered. With `start` accepted at edge t:
  - the first pattern value appears on `btn_out` after edge t+1;
  - `busy`=1 from t+1 through t+D.
- Total drive length: D = unit·(n(n+1)/2 + n) + settle, using the adjusted `unit` and `settle` values.
- At t+D+1:
  - `busy`=0 and `done`=1 for exactly one cycle;
  - `btn_out` holds `level`;
  - a `start` in this same cycle is accepted, so back-to-back patterns have no gap cycle.
- `start` and `rst` together: reset wins.

## Structure
- Package `bounce_gen_pkg` contains:
  - the state enum typedef (`bg_state_t`);
  - the default parameter constants, shared with the bench and the loopback top.
- One natural sub-module, `phase_timer`:
  - loadable down-counter with a `zero` flag;
  - loaded at each phase entry with k·unit, unit or settle.
- The k·unit product is formed by accumulation: add `unit` each time k increments. No multiplier.

## Test plan
- Reset, then idle 5 cycles:
  - required: `btn_out`=0, `busy`=0, `done`=0 throughout.
- `level`=1, n=2, unit=1, settle=3, `start` at edge 10:
  - required: `btn_out` sequence 1,0,1,1,0,1,1,1 on cycles 11–18;
  - required: `done`=1 at cycle 19 only, `btn_out` stays 1.
- n=0, unit=0, settle=0, `level`=1:
  - required: one cycle of 1, then `done`, so D=1.
- Pattern with `level`=0 immediately followed by a pattern with `level`=1, `start` held high:
  - required: second pattern's first value at the cycle after `done`;
  - required: toggles of `start` mid-pattern are ignored.
- `rst`=0 asserted in the middle of the GAP phase of bounce 3 (n=4, unit=2):
  - required at the next edge: `btn_out`=0, `busy`=0, no `done`;
  - required: a new `start` is accepted normally.
- Loopback into `debounce` with N=$clog2(MAX_BOUNCE), n=MAX_BOUNCE, unit=1, settle=16, `level`=1:
  - required: `result` rises exactly once and never during the bounce phases.
